ram16_loader: RTL and testbench

//  Writer-side counterpart of the 16x1 lookup ROM: a 16-entry x 1-bit RAM programmed from

---
 rtl/ram16_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 57 +++++
 rtl/ram16_loader.sv | 157 +++++++++++++++
 tb/tb_ram16_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram16_pkg.sv
// ============================================================================
// Module   : ram16_pkg
// Purpose  : Shared constants and FSM state encoding for the 16x1 RAM loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ram16_pkg;

    localparam int RAM_DEPTH = 16;
    localparam int RAM_AW    = 4;
    localparam int COUNT_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_REPORT  = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module   : sw_debounce
// Purpose  : 2-FF synchroniser plus counter debouncer for a bouncy switch,
//            with a one-cycle pulse on each accepted rising edge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            // The count measures consecutive cycles of disagreement; any agreement restarts it.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/ram16_loader.sv
// ============================================================================
// Module   : ram16_loader
// Purpose  : 16x1 flop RAM programmed from debounced switches, with write
//            verify, clear sequence and an independent registered read port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram16_loader
    import ram16_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               wr_sw,
    input  logic               clr_sw,
    input  logic [RAM_AW-1:0]  wr_addr,
    input  logic               wr_data,
    input  logic [RAM_AW-1:0]  rd_addr,
    output logic               rd_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] wr_count
);

    localparam logic [RAM_AW-1:0] c_last_idx = RAM_AW'(RAM_DEPTH - 1);

    logic w_wr_level;
    logic w_wr_rise;
    logic w_clr_level;
    logic w_clr_rise;

    state_t               r_state;
    logic [RAM_DEPTH-1:0] r_mem;
    logic [RAM_AW-1:0]    r_addr_q;
    logic                 r_data_q;
    logic [RAM_AW-1:0]    r_clr_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_rd_data;

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_wr_db (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .raw      (wr_sw),
        .level    (w_wr_level),
        .rise     (w_wr_rise)
    );

    sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_clr_db (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .raw      (clr_sw),
        .level    (w_clr_level),
        .rise     (w_clr_rise)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_mem     <= '0;
            r_addr_q  <= '0;
            r_data_q  <= 1'b0;
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Clear takes priority; a simultaneous write press is dropped.
                    if (w_clr_rise) begin
                        r_clr_idx <= '0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CLEAR;
                    end else if (w_wr_rise) begin
                        r_busy  <= 1'b1;
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_addr_q <= wr_addr;
                    r_data_q <= wr_data;
                    r_error  <= 1'b0;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_mem[r_addr_q] <= r_data_q;
                    r_state         <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    // done is raised here so it is visible during REPORT.
                    if (r_mem[r_addr_q] == r_data_q) begin
                        r_count <= r_count + COUNT_W'(1);
                        r_done  <= 1'b1;
                    end else begin
                        r_error <= 1'b1;
                    end
                    r_state <= ST_REPORT;
                end
                ST_CLEAR: begin
                    r_mem[r_clr_idx] <= 1'b0;
                    r_clr_idx        <= r_clr_idx + RAM_AW'(1);
                    if (r_clr_idx == c_last_idx) begin
                        r_done  <= !r_error;
                        r_state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!w_wr_level && !w_clr_level) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-before-write: a same-address write lands on the same edge as this sample.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_data <= 1'b0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data  = r_rd_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign wr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ram16_loader.sv
// ============================================================================
// Module   : tb_ram16_loader
// Purpose  : Scoreboard bench for ram16_loader with a behavioural RAM model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram16_loader;

    localparam int DB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       wr_sw    = 1'b0;
    logic       clr_sw   = 1'b0;
    logic [3:0] wr_addr  = 4'h0;
    logic       wr_data  = 1'b0;
    logic [3:0] rd_addr  = 4'h0;
    logic       rd_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] wr_count;

    typedef struct {
        bit         is_clr;
        logic [7:0] count;
    } done_exp_t;

    done_exp_t  done_q[$];
    bit         rd_q[$];
    bit         model_mem[16];
    logic [7:0] model_count = 8'd0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_rise_cyc = 0;
    logic busy_prev = 1'b0;
    logic rd_vld = 1'b0;
    logic rd_pend = 1'b0;

    ram16_loader #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .wr_sw    (wr_sw),
        .clr_sw   (clr_sw),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wr_count (wr_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) rd_pend <= 1'b0;
        else          rd_pend <= rd_vld;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents done or read data.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (RESET_N) begin
                if (busy && !busy_prev) busy_rise_cyc = cyc;
                busy_prev = busy;
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("done_expected", 32'(done_q.size()), 1);
                    end else begin
                        e = done_q.pop_front();
                        check("done_wr_count", 32'(wr_count), 32'(e.count));
                        check("done_error", 32'(error), 0);
                        check(e.is_clr ? "clr_latency" : "wr_latency",
                              32'(cyc - busy_rise_cyc), e.is_clr ? 32'd16 : 32'd3);
                    end
                end
                if (rd_pend) begin
                    if (rd_q.size() == 0) check("read_expected", 32'(rd_q.size()), 1);
                    else                  check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
                end
            end else begin
                busy_prev = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            tick(1);
            k++;
        end
        check("idle_timeout", 32'(busy), 0);
        check("done_missing", 32'(done_q.size()), 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            tick(1);
            rd_addr = 4'(a);
            rd_vld  = 1'b1;
            rd_q.push_back(model_mem[a]);
        end
        tick(1);
        rd_vld = 1'b0;
        tick(2);
    endtask

    task automatic do_write(input logic [3:0] a, input logic d, input int hold);
        model_mem[a] = d;
        model_count  = model_count + 8'd1;
        done_q.push_back('{1'b0, model_count});
        wr_addr = a;
        wr_data = d;
        wr_sw   = 1'b1;
        tick(hold);
        wr_sw   = 1'b0;
        // Switch motion after the latch must not disturb the stored write.
        wr_addr = 4'($urandom);
        wr_data = 1'($urandom);
        wait_idle();
    endtask

    task automatic do_clear(input int hold, input bit with_wr);
        for (int a = 0; a < 16; a++) model_mem[a] = 1'b0;
        done_q.push_back('{1'b1, model_count});
        clr_sw = 1'b1;
        if (with_wr) wr_sw = 1'b1;
        tick(hold);
        clr_sw = 1'b0;
        wr_sw  = 1'b0;
        wait_idle();
    endtask

    task automatic bounce_then_write(input logic [3:0] a, input logic d);
        int n = $urandom_range(1, 4);
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < n; i++) begin
            wr_sw = 1'b1;
            tick($urandom_range(1, 3));
            wr_sw = 1'b0;
            tick($urandom_range(1, 2));
        end
        do_write(a, d, $urandom_range(10, 25));
    endtask

    initial begin
        int busy_seen;
        for (int a = 0; a < 16; a++) model_mem[a] = 1'b0;

        // Reset state
        tick(3);
        RESET_N = 1'b1;
        tick(2);
        check("reset_rd_data", 32'(rd_data), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_wr_count", 32'(wr_count), 0);

        // Single clean write
        do_write(4'hA, 1'b1, 20);
        check("wr_count_after_first", 32'(wr_count), 1);
        read_all();

        // Bouncing switch must never be accepted
        busy_seen = 0;
        for (int i = 0; i < 15; i++) begin
            wr_sw = ~wr_sw;
            repeat (2) begin
                tick(1);
                if (busy) busy_seen++;
            end
        end
        wr_sw = 1'b0;
        repeat (20) begin
            tick(1);
            if (busy) busy_seen++;
        end
        check("bounce_busy_cycles", 32'(busy_seen), 0);
        check("bounce_wr_count", 32'(wr_count), 32'(model_count));

        // Writes then clear
        do_write(4'h0, 1'b1, 12);
        do_write(4'h5, 1'b1, 12);
        do_write(4'hF, 1'b1, 12);
        read_all();
        do_clear(12, 1'b0);
        check("clear_keeps_count", 32'(wr_count), 32'(model_count));
        read_all();

        // Long hold gives one write, a second press gives another
        do_write(4'h3, 1'b1, 200);
        do_write(4'h7, 1'b1, 15);
        check("long_hold_count", 32'(wr_count), 32'(model_count));

        // Simultaneous presses: clear wins
        do_clear(15, 1'b1);
        read_all();

        // Randomised writes with bounce, enough to wrap the counter
        for (int i = 0; i < 250; i++) begin
            bounce_then_write(4'($urandom), 1'($urandom));
            if (i % 50 == 49) read_all();
        end
        check("wrap_wr_count", 32'(wr_count), 32'(model_count));
        read_all();

        // Reset in the middle of a clear sequence
        do_write(4'hC, 1'b1, 12);
        do_write(4'h9, 1'b1, 12);
        rd_addr = 4'hC;
        clr_sw  = 1'b1;
        begin
            int k = 0;
            while (!busy && k < 40) begin
                tick(1);
                k++;
            end
        end
        check("clear_started", 32'(busy), 1);
        tick(7);
        check("pre_reset_rd_data", 32'(rd_data), 1);
        #2;
        RESET_N = 1'b0;
        clr_sw  = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_error", 32'(error), 0);
        check("async_rst_wr_count", 32'(wr_count), 0);
        check("async_rst_rd_data", 32'(rd_data), 0);
        done_q.delete();
        rd_q.delete();
        for (int a = 0; a < 16; a++) model_mem[a] = 1'b0;
        model_count = 8'd0;
        tick(3);
        RESET_N = 1'b1;
        tick(3);
        check("post_reset_busy", 32'(busy), 0);
        read_all();
        do_write(4'h2, 1'b1, 12);
        read_all();

        check("done_q_empty", 32'(done_q.size()), 0);
        check("rd_q_empty", 32'(rd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
